// File: rtl/lzc_norm_pipe_if.sv
// Purpose : beat-level bus of the leading-run counter / normaliser (input beat + result beat).
// Latency : n/a (wires only).
// Backpressure: in_ready_O / out_ready_I valid-ready pairs; slave = the pipe, master = its driver.
interface lzc_norm_pipe_if #(
    parameter int C_WIDTH         = 51,
    parameter int C_LEADONE_WIDTH = 6,
    parameter int C_TAG_WIDTH     = 4
);
    // input beat
    logic                       in_valid_I;
    logic                       in_ready_O;
    logic [C_WIDTH-1:0]         data_I;
    logic                       mode_I;
    logic [C_LEADONE_WIDTH-1:0] max_shift_I;
    logic [C_TAG_WIDTH-1:0]     tag_I;
    // result beat
    logic                       out_valid_O;
    logic                       out_ready_I;
    logic [C_WIDTH-1:0]         data_O;
    logic [C_LEADONE_WIDTH-1:0] lz_cnt_O;
    logic [C_LEADONE_WIDTH-1:0] shift_O;
    logic                       all_same_O;
    logic                       clamped_O;
    logic [C_TAG_WIDTH-1:0]     tag_O;

    modport slave (
        input  in_valid_I, data_I, mode_I, max_shift_I, tag_I, out_ready_I,
        output in_ready_O, out_valid_O, data_O, lz_cnt_O, shift_O, all_same_O, clamped_O, tag_O
    );

    modport master (
        output in_valid_I, data_I, mode_I, max_shift_I, tag_I, out_ready_I,
        input  in_ready_O, out_valid_O, data_O, lz_cnt_O, shift_O, all_same_O, clamped_O, tag_O
    );
endinterface

// File: rtl/lzc_norm_pipe.sv
// Purpose : leading-zero/one count (stage 1) then clamped normalising left shift (stage 2).
// Latency : result valid two cycles after the beat is presented (one register per stage).
// Backpressure: in_ready_O = stage 1 can advance; combinational from out_ready_I, never from in_valid_I.
// Ports   : clk_I / rst_n_I (async active-low); io = lzc_norm_pipe_if.slave carrying the
//           input beat (data, mode, max_shift, tag) and the result beat (shifted data, count,
//           applied shift, all_same, clamped, tag).
module lzc_norm_pipe #(
    parameter int C_WIDTH         = 51,
    parameter int C_LEADONE_WIDTH = 6,
    parameter int C_TAG_WIDTH     = 4
) (
    input  logic          clk_I,
    input  logic          rst_n_I,
    lzc_norm_pipe_if.slave io
);
    localparam int LW = C_LEADONE_WIDTH;
    localparam logic [LW-1:0] C_WIDTH_CNT = LW'(C_WIDTH);

    // stage 1: operand plus its leading-run count
    logic                   s1_vld_q,  s1_vld_d;
    logic [C_WIDTH-1:0]     s1_data_q, s1_data_d;
    logic [LW-1:0]          s1_max_q,  s1_max_d;
    logic [C_TAG_WIDTH-1:0] s1_tag_q,  s1_tag_d;
    logic [LW-1:0]          s1_cnt_q,  s1_cnt_d;
    logic                   s1_same_q, s1_same_d;

    // stage 2: normalised result
    logic                   s2_vld_q,   s2_vld_d;
    logic [C_WIDTH-1:0]     s2_data_q,  s2_data_d;
    logic [LW-1:0]          s2_cnt_q,   s2_cnt_d;
    logic [LW-1:0]          s2_shift_q, s2_shift_d;
    logic                   s2_clamp_q, s2_clamp_d;
    logic                   s2_same_q,  s2_same_d;
    logic [C_TAG_WIDTH-1:0] s2_tag_q,   s2_tag_d;

    logic                   s1_adv, s2_adv;
    logic [LW-1:0]          in_cnt;
    logic                   in_run;
    logic                   clamp;
    logic [LW-1:0]          shift;

    // Leading-run count: in_run stays high while bits still match mode_I; if it
    // survives the whole word there was no terminating bit.
    always_comb begin
        in_cnt = '0;
        in_run = 1'b1;
        for (int i = C_WIDTH - 1; i >= 0; i--) begin
            if (in_run && (io.data_I[i] == io.mode_I)) begin
                in_cnt = in_cnt + LW'(1);
            end else begin
                in_run = 1'b0;
            end
        end
    end

    // Clamp against the beat's own limit. An all-same operand with a large
    // limit lands on shift == C_WIDTH, which must flush the data to zero.
    always_comb begin
        clamp = (s1_cnt_q > s1_max_q);
        shift = clamp ? s1_max_q : s1_cnt_q;
    end

    always_comb begin
        s2_adv = ~s2_vld_q | io.out_ready_I;
        s1_adv = ~s1_vld_q | s2_adv;

        s1_vld_d   = s1_vld_q;
        s1_data_d  = s1_data_q;
        s1_max_d   = s1_max_q;
        s1_tag_d   = s1_tag_q;
        s1_cnt_d   = s1_cnt_q;
        s1_same_d  = s1_same_q;
        s2_vld_d   = s2_vld_q;
        s2_data_d  = s2_data_q;
        s2_cnt_d   = s2_cnt_q;
        s2_shift_d = s2_shift_q;
        s2_clamp_d = s2_clamp_q;
        s2_same_d  = s2_same_q;
        s2_tag_d   = s2_tag_q;

        if (s1_adv) begin
            s1_vld_d = io.in_valid_I;
            if (io.in_valid_I) begin
                s1_data_d = io.data_I;
                s1_max_d  = io.max_shift_I;
                s1_tag_d  = io.tag_I;
                s1_cnt_d  = in_cnt;
                s1_same_d = in_run;
            end
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_data_d  = (shift >= C_WIDTH_CNT) ? '0 : (s1_data_q << shift);
                s2_cnt_d   = s1_cnt_q;
                s2_shift_d = shift;
                s2_clamp_d = clamp;
                s2_same_d  = s1_same_q;
                s2_tag_d   = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk_I or negedge rst_n_I) begin
        if (!rst_n_I) begin
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            s1_max_q   <= '0;
            s1_tag_q   <= '0;
            s1_cnt_q   <= '0;
            s1_same_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_data_q  <= '0;
            s2_cnt_q   <= '0;
            s2_shift_q <= '0;
            s2_clamp_q <= 1'b0;
            s2_same_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_data_q  <= s1_data_d;
            s1_max_q   <= s1_max_d;
            s1_tag_q   <= s1_tag_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_same_q  <= s1_same_d;
            s2_vld_q   <= s2_vld_d;
            s2_data_q  <= s2_data_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_shift_q <= s2_shift_d;
            s2_clamp_q <= s2_clamp_d;
            s2_same_q  <= s2_same_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign io.in_ready_O  = s1_adv;
    assign io.out_valid_O = s2_vld_q;
    assign io.data_O      = s2_data_q;
    assign io.lz_cnt_O    = s2_cnt_q;
    assign io.shift_O     = s2_shift_q;
    assign io.all_same_O  = s2_same_q;
    assign io.clamped_O   = s2_clamp_q;
    assign io.tag_O       = s2_tag_q;
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Purpose : self-checking bench for lzc_norm_pipe (W=8, count width 4, tag width 4).
// Latency : results expected two cycles after presentation when unstalled.
// Backpressure: out_ready_I driven directed and random; scoreboard follows actual transfers.
module tb_lzc_norm_pipe;
    localparam int W  = 8;
    localparam int LW = 4;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [LW-1:0] lz;
        logic [LW-1:0] sh;
        logic          cl;
        logic          as;
        logic [TW-1:0] tag;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lzc_norm_pipe_if #(.C_WIDTH(W), .C_LEADONE_WIDTH(LW), .C_TAG_WIDTH(TW)) bus ();

    lzc_norm_pipe #(.C_WIDTH(W), .C_LEADONE_WIDTH(LW), .C_TAG_WIDTH(TW)) dut (
        .clk_I  (clk),
        .rst_n_I(rst_n),
        .io     (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    res_t q[$];
    bit   sb_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: walk the word MSB-first counting bits equal to the mode,
    // then apply min(count, limit) as a plain left shift.
    function automatic res_t model(input logic [W-1:0] d, input logic m,
                                   input logic [LW-1:0] mx, input logic [TW-1:0] t);
        res_t r;
        int   n = 0;
        int   s;
        while (n < W && d[W-1-n] == m) n++;
        s     = (n > int'(mx)) ? int'(mx) : n;
        r.lz  = LW'(n);
        r.sh  = LW'(s);
        r.cl  = (n > int'(mx));
        r.as  = (n == W);
        r.d   = (s >= W) ? '0 : W'(d << s);
        r.tag = t;
        return r;
    endfunction

    function automatic logic [31:0] dut_res();
        return 32'({bus.data_O, bus.lz_cnt_O, bus.shift_O, bus.clamped_O, bus.all_same_O, bus.tag_O});
    endfunction

    // Scoreboard: inputs and ready are stable at the falling edge, so the
    // transfers about to happen on the next rising edge are decided here.
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            if (bus.out_valid_O) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_beat", 32'(bus.out_valid_O), 32'd0);
                end else begin
                    chk("sb_beat", dut_res(), 32'(q[0]));
                    if (bus.out_ready_I) void'(q.pop_front());
                end
            end
            if (bus.in_valid_I && bus.in_ready_O)
                q.push_back(model(bus.data_I, bus.mode_I, bus.max_shift_I, bus.tag_I));
        end
    end

    task automatic directed(input string nm, input logic [W-1:0] d, input logic m,
                            input logic [LW-1:0] mx, input logic [TW-1:0] t, input res_t e);
        chk({nm, "_model"}, 32'(model(d, m, mx, t)), 32'(e));
        @(posedge clk); #1;
        bus.in_valid_I  = 1'b1;
        bus.data_I      = d;
        bus.mode_I      = m;
        bus.max_shift_I = mx;
        bus.tag_I       = t;
        bus.out_ready_I = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(bus.in_ready_O), 32'd1);
        @(posedge clk); #1;
        bus.in_valid_I = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_out"}, {bus.out_valid_O, dut_res()}, {1'b1, 32'(e)});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        bus.in_valid_I  = 1'b0;
        bus.data_I      = '0;
        bus.mode_I      = 1'b0;
        bus.max_shift_I = '0;
        bus.tag_I       = '0;
        bus.out_ready_I = 1'b1;

        // reset values
        #1;
        chk("rst_out_valid", 32'(bus.out_valid_O), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready_O),  32'd1);
        chk("rst_outputs",   dut_res(),            32'd0);
        #22 rst_n = 1'b1;
        sb_en = 1'b1;

        // hand-computed cases
        directed("lzc_10",   8'h10, 1'b0, 4'd15, 4'd3, '{8'h80, 4'd3, 4'd3, 1'b0, 1'b0, 4'd3});
        directed("loc_e5",   8'hE5, 1'b1, 4'd15, 4'd5, '{8'h28, 4'd3, 4'd3, 1'b0, 1'b0, 4'd5});
        directed("zero_big", 8'h00, 1'b0, 4'd15, 4'd6, '{8'h00, 4'd8, 4'd8, 1'b0, 1'b1, 4'd6});
        directed("zero_cl5", 8'h00, 1'b0, 4'd5,  4'd7, '{8'h00, 4'd8, 4'd5, 1'b1, 1'b1, 4'd7});
        directed("one_cl4",  8'h01, 1'b0, 4'd4,  4'd8, '{8'h10, 4'd7, 4'd4, 1'b1, 1'b0, 4'd8});
        directed("ff_max8",  8'hFF, 1'b1, 4'd8,  4'd9, '{8'h00, 4'd8, 4'd8, 1'b0, 1'b1, 4'd9});
        directed("msb_set",  8'h80, 1'b0, 4'd0,  4'd1, '{8'h80, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1});

        // stream tags 0..7, stall output during cycles 3..6
        sent = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            bus.out_ready_I = !(k >= 3 && k <= 6);
            if (sent < 8) begin
                bus.in_valid_I  = 1'b1;
                bus.tag_I       = TW'(sent);
                bus.data_I      = W'($urandom);
                bus.mode_I      = 1'($urandom);
                bus.max_shift_I = LW'($urandom);
            end else begin
                bus.in_valid_I = 1'b0;
            end
            @(negedge clk);
            if (k == 4) begin
                chk("stall_in_ready",  32'(bus.in_ready_O),  32'd0);
                chk("stall_out_valid", 32'(bus.out_valid_O), 32'd1);
                chk("stall_tag",       32'(bus.tag_O),       32'd1);
            end
            if (k >= 7 && k <= 13) begin
                chk("stream_no_gap", 32'(bus.out_valid_O), 32'd1);
                chk("stream_tag",    32'(bus.tag_O),       32'(k - 6));
            end
            if (bus.in_valid_I && bus.in_ready_O) sent++;
        end
        chk("stream_all_sent", 32'(sent), 32'd8);

        // mid-stream reset with two beats in flight
        @(posedge clk); #1;
        bus.out_ready_I = 1'b0;
        bus.in_valid_I  = 1'b1;
        bus.data_I      = 8'h0F;
        bus.tag_I       = 4'hA;
        @(posedge clk); #1;
        bus.tag_I = 4'hB;
        @(posedge clk); #1;
        bus.in_valid_I = 1'b0;
        chk("mid_pre_valid", 32'(bus.out_valid_O), 32'd1);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid_O), 32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready_O),  32'd1);
        chk("mid_rst_outputs",   dut_res(),            32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready_I = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("mid_no_stale", 32'(bus.out_valid_O), 32'd0);
        repeat (3) @(posedge clk);

        // random traffic with random backpressure
        for (int k = 0; k < 600; k++) begin
            logic m;
            logic [W-1:0] d;
            @(posedge clk); #1;
            m = 1'($urandom);
            d = W'($urandom) >> $urandom_range(0, W);
            bus.in_valid_I  = ($urandom_range(0, 3) != 0);
            bus.out_ready_I = ($urandom_range(0, 3) != 0);
            bus.mode_I      = m;
            bus.data_I      = m ? ~d : d;
            bus.max_shift_I = LW'($urandom_range(0, 15));
            bus.tag_I       = TW'($urandom);
        end

        // drain
        @(posedge clk); #1;
        bus.in_valid_I  = 1'b0;
        bus.out_ready_I = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
